queue_wr_arbiter: RTL and testbench
===================================

// Module: queue_wr_arbiter
// PURPOSE
//   Shares the single write port of one `queue` instance between NREQ byte-stream requesters (e.g. EP IN sources).
//   Round-robin arbitration with packet lock: a granted requester keeps the port until its byte flagged `last` is written.
//   Generates the queue's write data and w_clk strobe from the system clock; honours q_full; bounds packet length.
// PARAMETERS
//   NREQ     2   number of requesters (2..8)
//   DW       8   data width, must match queue data_in
//   MAX_PKT  64  max bytes per locked packet; byte MAX_PKT without last forces release
// PORTS
//   clk        in   1         system clock, all logic on rising edge
//   rst        in   1         asynchronous, active-high reset
//   req_valid  in   NREQ      requester i has a byte on req_data[i]
//   req_data   in   NREQ*DW   packed bytes, requester i at [i*DW +: DW]
//   req_last   in   NREQ      byte on req_data[i] ends its packet
//   req_ready  out  NREQ      byte of requester i accepted this cycle (combinational, one-hot or zero)
//   q_data_in  out  DW        registered byte to queue data_in
//   q_w_clk    out  1         registered write strobe to queue w_clk (queue writes on its rising edge)
//   q_full     in   1         queue full flag
//   grant      out  NREQ      one-hot current owner, 0 when unowned
//   pkt_err    out  1         one-cycle pulse: packet forcibly truncated at MAX_PKT
// BEHAVIOUR
//   Reset: q_w_clk=0, q_data_in=0, grant=0, req_ready=0, pkt_err=0, byte_cnt=0, rr_ptr=NREQ-1 (req 0 wins first), state=ACCEPT.
//   FSM ACCEPT -> STROBE -> RECOVER -> ACCEPT; one byte per 3 clocks max.
//   ACCEPT, unowned: pick first i with req_valid[i], searching rr_ptr+1, +2 ... mod NREQ; set grant, rr_ptr=i.
//     The pick and the first byte accept happen in the same cycle if !q_full.
//   ACCEPT, owned (grant[o]): if req_valid[o] && !q_full: req_ready[o]=1, q_data_in<=req_data[o], byte_cnt++, -> STROBE.
//     Otherwise stay in ACCEPT; owner keeps the grant indefinitely while idle (no timeout).
//   STROBE: q_w_clk=1 for exactly one cycle; q_data_in stable. -> RECOVER.
//   RECOVER: q_w_clk=0; q_full is re-sampled only from the following ACCEPT (queue flag settles).
//     If the accepted byte had last=1: grant<=0, byte_cnt<=0.
//     Else if byte_cnt==MAX_PKT: grant<=0, byte_cnt<=0, pkt_err pulses in this cycle.
//   Non-owners never see req_ready while a packet is locked, regardless of their valid.
//   q_full asserted during STROBE/RECOVER does not cancel the in-flight write; the byte was accepted before full was seen.
//   rr_ptr is updated only at grant time; release makes the next search start after the last owner (fairness).
//   byte_cnt width clog2(MAX_PKT+1); no wrap (cleared at release).
//   Reset mid-STROBE drops q_w_clk immediately (async); the partially strobed byte is not retried; the packet is abandoned.
//   req_valid must remain stable with its data until req_ready; the block does not check this.
// STRUCTURE
//   Shared package (queue_pkg.vh): FSM state localparams (ST_ACCEPT, ST_STROBE, ST_RECOVER) and the default MAX_PKT.
//   Sub-module rr_pick #(NREQ): combinational round-robin picker (req vector, rr_ptr) -> one-hot + index + any.
//   Top: FSM, owner/grant register, byte counter, output registers.
// TESTING (bench instantiates queue #(.size(256)) behind the arbiter; reads drained via r_clk)
//   1 Single requester: req0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) -> queue reads 11,22,33; each byte accepted every 3 clocks; grant returns to 0.
//   2 Fairness: req0 and req1 both stream 2-byte packets continuously -> grants alternate 0,1,0,1; packets never interleave bytes.
//   3 Lock: req1 raises valid mid-packet of req0 (4 bytes A0..A3) -> req1 gets no ready until A3 written; then req1 is granted.
//   4 Full: queue size 4 pre-filled with 3 bytes, req0 sends 3 bytes -> 1 byte written, then req_ready stays 0 while full; after 2 reads the rest complete in order.
//   5 Overlong: MAX_PKT=4, req0 sends 6 bytes without last -> 4 written, pkt_err pulses once, grant drops; remaining bytes form a new grant.
//   6 Reset: assert rst during STROBE -> q_w_clk=0 and grant=0 immediately; after release req0 wins first arbitration.

Source files
------------

// File: rtl/queue_wr_arbiter_pkg.sv
// Shared types and defaults for the queue write-port arbiter.
package queue_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        StAccept  = 2'd0,
        StStrobe  = 2'd1,
        StRecover = 2'd2
    } arb_state_e;

    localparam int unsigned DefaultMaxPkt = 64;

endpackage

// File: rtl/queue_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after rr_ptr, wrapping mod NREQ.
module queue_wr_arbiter_rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   pick_idx,
    output logic            any
);

    logic [IW-1:0] cand;

    always_comb begin
        pick_idx = '0;
        any      = 1'b0;
        cand     = '0;
        // Offsets 1..NREQ so the last winner is searched last.
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IW'((int'(rr_ptr) + k) % int'(NREQ));
            if (!any && req[cand]) begin
                any      = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign pick = any ? (NREQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/queue_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one queue write port between NREQ byte streams.
module queue_wr_arbiter
    import queue_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned DW      = 8,
    parameter int unsigned MAX_PKT = DefaultMaxPkt
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic [DW-1:0]      q_data_in,
    output logic               q_w_clk,
    input  logic               q_full,
    output logic [NREQ-1:0]    grant,
    output logic               pkt_err
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAX_PKT + 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
    logic            last_q, last_d;
    logic [DW-1:0]   data_q, data_d;
    logic            w_clk_q;

    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            owned;
    logic [IW-1:0]   sel_idx;
    logic [DW-1:0]   req_bytes [NREQ];

    queue_wr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req      (req_valid),
        .rr_ptr   (rr_ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            req_bytes[i] = req_data[i*DW +: DW];
        end
    end

    assign owned   = |grant_q;
    assign sel_idx = owned ? owner_q : pick_idx;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        last_d     = last_q;
        data_d     = data_q;
        req_ready  = '0;
        pkt_err    = 1'b0;

        unique case (state_q)
            StAccept: begin
                if (!owned && pick_any) begin
                    grant_d  = pick;
                    owner_d  = pick_idx;
                    rr_ptr_d = pick_idx;
                end
                // Grant and first byte may be taken in the same cycle.
                if ((owned || pick_any) && req_valid[sel_idx] && !q_full) begin
                    req_ready[sel_idx] = 1'b1;
                    data_d             = req_bytes[sel_idx];
                    last_d             = req_last[sel_idx];
                    byte_cnt_d         = byte_cnt_q + CW'(1);
                    state_d            = StStrobe;
                end
            end
            StStrobe: begin
                state_d = StRecover;
            end
            StRecover: begin
                state_d = StAccept;
                if (last_q) begin
                    grant_d    = '0;
                    byte_cnt_d = '0;
                end else if (byte_cnt_q == CW'(MAX_PKT)) begin
                    grant_d    = '0;
                    byte_cnt_d = '0;
                    pkt_err    = 1'b1;
                end
            end
            default: begin
                state_d = StAccept;
            end
        endcase

        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StAccept;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= IW'(NREQ - 1);
            byte_cnt_q <= '0;
            last_q     <= 1'b0;
            data_q     <= '0;
            w_clk_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            last_q     <= last_d;
            data_q     <= data_d;
            w_clk_q    <= (state_d == StStrobe);
        end
    end

    assign q_data_in = data_q;
    assign q_w_clk   = w_clk_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_queue_wr_arbiter.sv
// Directed bench for queue_wr_arbiter with a behavioural queue and per-cycle reference model.
module tb_queue_wr_arbiter;

    localparam int unsigned NREQ    = 3;
    localparam int unsigned DW      = 8;
    localparam int unsigned MAX_PKT = 4;

    typedef logic [7:0] bq_t[$];

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      q_data_in;
    logic               q_w_clk;
    logic               q_full;
    logic [NREQ-1:0]    grant;
    logic               pkt_err;

    always #5 clk = ~clk;

    queue_wr_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .MAX_PKT (MAX_PKT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .q_data_in (q_data_in),
        .q_w_clk   (q_w_clk),
        .q_full    (q_full),
        .grant     (grant),
        .pkt_err   (pkt_err)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural queue behind the write port.
    bq_t storage;
    int  q_size  = 256;
    int  q_count = 0;
    assign q_full = (q_count >= q_size);

    // Logs
    bq_t written;
    bq_t grant_log;
    int  acc_cycles[$];
    int  err_cnt = 0;
    int  cyc = 0;

    logic [8:0]      src [NREQ][$];
    logic [NREQ-1:0] acc_mask = '0;
    logic [NREQ-1:0] prev_grant = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bytes(input string name, input bq_t act, input bq_t exp);
        int bad;
        bad = -1;
        if (act.size() != exp.size()) bad = 0;
        else for (int i = 0; i < act.size(); i++) if (bad < 0 && act[i] !== exp[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: got %0d items (first %0h) expected %0d items (diff at %0d)",
                     name, act.size(), (act.size() > 0) ? act[0] : 8'h00, exp.size(), bad);
        end
    endtask

    // Reference model: owner index, round-robin pointer, phase since accept.
    int         m_owner, m_rr, m_phase, m_cnt, m_s;
    logic       m_last;
    logic [7:0] m_data;

    function automatic int m_sel();
        if (m_phase != 0) return -1;
        if (m_owner >= 0) return m_owner;
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_rr = NREQ - 1; m_phase = 0; m_cnt = 0; m_last = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    m_s = m_sel();
                    if (m_s >= 0) begin
                        if (m_owner < 0) begin m_owner = m_s; m_rr = m_s; end
                        if (req_valid[m_s] && !q_full) begin
                            m_data  = req_data[m_s*DW +: DW];
                            m_last  = req_last[m_s];
                            m_cnt   = m_cnt + 1;
                            m_phase = 1;
                        end
                    end
                end
                1: m_phase = 2;
                default: begin
                    if (m_last || m_cnt == int'(MAX_PKT)) begin m_owner = -1; m_cnt = 0; end
                    m_phase = 0;
                end
            endcase
        end
    end

    // Compare process and queue write/log capture, away from the rising edge.
    always @(negedge clk) begin
        int          e_s;
        logic [NREQ-1:0] e_ready;
        logic [NREQ-1:0] e_grant;
        if (!rst) begin
            e_s     = m_sel();
            e_ready = '0;
            if (e_s >= 0 && req_valid[e_s] && !q_full) e_ready[e_s] = 1'b1;
            e_grant = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("grant", 32'(grant), 32'(e_grant));
            check("q_w_clk", 32'(q_w_clk), 32'(m_phase == 1));
            check("pkt_err", 32'(pkt_err),
                  32'(m_phase == 2 && !m_last && m_cnt == int'(MAX_PKT)));
            if (m_phase == 1) check("q_data_in", 32'(q_data_in), 32'(m_data));
            if (q_w_clk) begin
                written.push_back(q_data_in);
                if (q_count < q_size) storage.push_back(q_data_in);
                q_count = storage.size();
            end
            if (grant != '0 && prev_grant == '0) begin
                for (int i = 0; i < int'(NREQ); i++) if (grant[i]) grant_log.push_back(8'(i));
            end
            prev_grant = grant;
            if (pkt_err) err_cnt++;
            if (req_ready[0]) acc_cycles.push_back(cyc);
            acc_mask = req_ready & req_valid;
        end else begin
            acc_mask   = '0;
            prev_grant = '0;
        end
    end

    // Requester sources: hold each byte until it is accepted.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (acc_mask[i] && src[i].size() > 0) void'(src[i].pop_front());
            if (src[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = src[i][0][7:0];
                req_last[i]          = src[i][0][8];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i]          = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src[r].push_back({l, d});
    endtask

    task automatic clear_all();
        for (int i = 0; i < int'(NREQ); i++) src[i].delete();
        storage.delete();
        q_count = 0;
        written.delete();
        grant_log.delete();
        acc_cycles.delete();
        err_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while (n < max && !(src[0].size() == 0 && src[1].size() == 0 && src[2].size() == 0
                            && grant == '0 && !q_w_clk)) begin
            step(1);
            n++;
        end
        if (n >= max) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles, grant %0h", name, n, grant);
        end
    endtask

    task automatic wait_written(input string name, input int cnt, input int max);
        int n;
        n = 0;
        while (n < max && written.size() < cnt) begin
            step(1);
            n++;
        end
        if (n >= max) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, written %0d required %0d", name, written.size(), cnt);
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        logic [7:0] v;
        v = (storage.size() > 0) ? storage.pop_front() : 8'hxx;
        q_count = storage.size();
        check(name, 32'(v), 32'(exp));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        step(2);
        check("rst q_w_clk", 32'(q_w_clk), 32'd0);
        check("rst q_data_in", 32'(q_data_in), 32'd0);
        check("rst grant", 32'(grant), 32'd0);
        check("rst pkt_err", 32'(pkt_err), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // 1: single requester, one byte per three clocks
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
        wait_idle("t1 idle", 100);
        check_bytes("t1 written", written, '{8'h11, 8'h22, 8'h33});
        check_bytes("t1 grants", grant_log, '{8'd0});
        check("t1 acc count", 32'(acc_cycles.size()), 32'd3);
        if (acc_cycles.size() == 3) begin
            check("t1 spacing a", 32'(acc_cycles[1] - acc_cycles[0]), 32'd3);
            check("t1 spacing b", 32'(acc_cycles[2] - acc_cycles[1]), 32'd3);
        end
        check("t1 grant released", 32'(grant), 32'd0);

        // 2: fairness with two continuous 2-byte streams
        do_reset();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
        push(1, 8'h81, 1'b0); push(1, 8'h82, 1'b1); push(1, 8'h83, 1'b0); push(1, 8'h84, 1'b1);
        wait_idle("t2 idle", 200);
        check_bytes("t2 written", written,
                    '{8'h01, 8'h02, 8'h81, 8'h82, 8'h03, 8'h04, 8'h83, 8'h84});
        check_bytes("t2 grants", grant_log, '{8'd0, 8'd1, 8'd0, 8'd1});

        // 3: lock, req1 arrives mid-packet; 4 bytes with last is not an overlong packet
        do_reset();
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        wait_written("t3 first", 1, 50);
        push(1, 8'hB0, 1'b1);
        wait_idle("t3 idle", 200);
        check_bytes("t3 written", written, '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0});
        check_bytes("t3 grants", grant_log, '{8'd0, 8'd1});
        check("t3 pkt_err count", 32'(err_cnt), 32'd0);

        // 4: queue full back-pressure
        do_reset();
        q_size = 4;
        storage.push_back(8'hE0); storage.push_back(8'hE1); storage.push_back(8'hE2);
        q_count = storage.size();
        push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b1);
        step(20);
        check_bytes("t4 stalled", written, '{8'hC0});
        check("t4 q_full", 32'(q_full), 32'd1);
        check("t4 owner kept", 32'(grant), 32'd1);
        check("t4 no ready", 32'(req_ready), 32'd0);
        pop_check("t4 read 0", 8'hE0);
        pop_check("t4 read 1", 8'hE1);
        wait_idle("t4 idle", 100);
        check_bytes("t4 written", written, '{8'hC0, 8'hC1, 8'hC2});
        check_bytes("t4 queue", storage, '{8'hE2, 8'hC0, 8'hC1, 8'hC2});
        q_size = 256;

        // 5: overlong packet truncated at MAX_PKT
        do_reset();
        for (int i = 0; i < 6; i++) push(0, 8'(8'h50 + i), 1'b0);
        wait_written("t5 bytes", 6, 200);
        step(6);
        check_bytes("t5 written", written, '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55});
        check("t5 pkt_err count", 32'(err_cnt), 32'd1);
        check_bytes("t5 grants", grant_log, '{8'd0, 8'd0});
        check("t5 grant held", 32'(grant), 32'd1);

        // 6: asynchronous reset during STROBE
        do_reset();
        push(0, 8'h77, 1'b0); push(0, 8'h78, 1'b1);
        begin
            int n;
            n = 0;
            while (n < 50 && !q_w_clk) begin step(1); n++; end
        end
        check("t6 strobe seen", 32'(q_w_clk), 32'd1);
        check("t6 grant before", 32'(grant), 32'd1);
        rst = 1'b1;
        #1;
        check("t6 q_w_clk async", 32'(q_w_clk), 32'd0);
        check("t6 grant async", 32'(grant), 32'd0);
        clear_all();
        step(1);
        rst = 1'b0;
        push(2, 8'h91, 1'b1);
        push(0, 8'h90, 1'b1);
        wait_idle("t6 idle", 100);
        check_bytes("t6 grants", grant_log, '{8'd0, 8'd2});
        check_bytes("t6 written", written, '{8'h90, 8'h91});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
